// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, owner IDs, field widths.
package sram_port_arbiter_pkg;

   localparam int unsigned WEN_W   = 4;
   localparam int unsigned STATE_W = 2;

   // Arbiter transaction FSM: at most one transaction outstanding on the shared port.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   // Requester identity, used both for the current owner and for round-robin history.
   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of fetch, load/store and shared-SRAM handshake signals around the arbiter.
interface sram_port_arbiter_if
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned DW = 32
);

   // Instruction fetch side
   logic             inst_req;
   logic [DW-1:0]    inst_addr;
   logic             inst_addr_ok;
   logic             inst_data_ok;
   logic [DW-1:0]    inst_rdata;

   // Load/store side
   logic             data_req;
   logic [WEN_W-1:0] data_wen;
   logic [DW-1:0]    data_addr;
   logic [DW-1:0]    data_wdata;
   logic             data_addr_ok;
   logic             data_data_ok;
   logic [DW-1:0]    data_rdata;

   // Shared SRAM-like port
   logic             mem_req;
   logic [WEN_W-1:0] mem_wen;
   logic [DW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic             mem_addr_ok;
   logic             mem_data_ok;
   logic [DW-1:0]    mem_rdata;

   // Pipeline stall request
   logic             stall_req;

   // Arbiter view
   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wen, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wen, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output stall_req
   );

   // Environment view: requesters, SRAM and stall controller
   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wen, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wen, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  stall_req
   );

endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
module rr_arb2
   import sram_port_arbiter_pkg::*;
(
   input  logic   inst_req,
   input  logic   data_req,
   input  owner_e last_owner,
   output logic   gnt_valid_c,
   output owner_e gnt_owner_c
);

   // Grant decode
   always_comb begin
      gnt_valid_c = inst_req | data_req;
      gnt_owner_c = OWN_INST;
      if (inst_req && data_req) begin
         if (last_owner == OWN_INST) begin
            gnt_owner_c = OWN_DATA;
         end else begin
            gnt_owner_c = OWN_INST;
         end
      end else if (data_req) begin
         gnt_owner_c = OWN_DATA;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto one SRAM-like port,
// one transaction outstanding at a time, with round-robin on simultaneous requests.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned DW = 32
)(
   input  logic               clk,
   input  logic               rst,
   sram_port_arbiter_if.slave bus
);

   state_e           state_q;
   owner_e           last_owner_q;
   owner_e           owner_q;
   logic [DW-1:0]    addr_q;
   logic [WEN_W-1:0] wen_q;
   logic [DW-1:0]    wdata_q;

   logic             gnt_valid;
   owner_e           gnt_owner;
   logic             grant_c;
   logic             complete_c;
   logic             is_read_c;

   rr_arb2 u_rr_arb2 (
      .inst_req    (bus.inst_req),
      .data_req    (bus.data_req),
      .last_owner  (last_owner_q),
      .gnt_valid_c (gnt_valid),
      .gnt_owner_c (gnt_owner)
   );

   // Transaction events for this cycle: a new grant out of IDLE, or completion from ADDR/WAIT
   always_comb begin
      grant_c    = 1'b0;
      complete_c = 1'b0;
      case (state_q)
         ST_IDLE: grant_c    = gnt_valid;
         ST_ADDR: complete_c = bus.mem_addr_ok & bus.mem_data_ok;
         ST_WAIT: complete_c = bus.mem_data_ok;
         default: begin
            grant_c    = 1'b0;
            complete_c = 1'b0;
         end
      endcase
   end

   assign is_read_c = (wen_q == WEN_W'(0));

   // FSM and captured request; requester inputs are only sampled on the grant edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_owner_q <= OWN_INST;
         owner_q      <= OWN_INST;
         addr_q       <= '0;
         wen_q        <= '0;
         wdata_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_valid) begin
                  state_q <= ST_ADDR;
                  owner_q <= gnt_owner;
                  if (gnt_owner == OWN_DATA) begin
                     addr_q  <= bus.data_addr;
                     wen_q   <= bus.data_wen;
                     wdata_q <= bus.data_wdata;
                  end else begin
                     addr_q  <= bus.inst_addr;
                     wen_q   <= '0;
                     wdata_q <= '0;
                  end
               end
            end
            ST_ADDR: begin
               if (complete_c) begin
                  state_q      <= ST_IDLE;
                  last_owner_q <= owner_q;
               end else if (bus.mem_addr_ok) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (complete_c) begin
                  state_q      <= ST_IDLE;
                  last_owner_q <= owner_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Address handshake back to the requesters; only the granted side sees addr_ok
   assign bus.inst_addr_ok = ~rst & grant_c & (gnt_owner == OWN_INST);
   assign bus.data_addr_ok = ~rst & grant_c & (gnt_owner == OWN_DATA);

   // Completion goes to the owner in the same cycle as mem_data_ok; rdata is zero unless a read completes
   assign bus.inst_data_ok = ~rst & complete_c & (owner_q == OWN_INST);
   assign bus.data_data_ok = ~rst & complete_c & (owner_q == OWN_DATA);
   assign bus.inst_rdata   = (bus.inst_data_ok && is_read_c) ? bus.mem_rdata : '0;
   assign bus.data_rdata   = (bus.data_data_ok && is_read_c) ? bus.mem_rdata : '0;

   // Shared port: request only in ADDR, fields always reflect the captured transaction
   assign bus.mem_req   = ~rst & (state_q == ST_ADDR);
   assign bus.mem_wen   = wen_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

   // Stall while a request waits in IDLE or a transaction is in flight and not finishing now
   assign bus.stall_req = ~rst & (((state_q == ST_IDLE) & (bus.inst_req | bus.data_req)) |
                                  ((state_q != ST_IDLE) & ~complete_c));

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning address/data width.
REQ-002 SHALL have clk input 1: clock, all state updates on rising edge.
REQ-003 SHALL have rst input 1: reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have inst_req input 1: fetch request, read only.
REQ-005 SHALL have inst_addr input DW: fetch address.
REQ-006 SHALL have inst_addr_ok output 1: fetch request accepted.
REQ-007 SHALL have inst_data_ok output 1: fetch data valid.
REQ-008 SHALL have inst_rdata output DW: fetch read data.
REQ-009 SHALL have data_req input 1: load/store request.
REQ-010 SHALL have data_wen input 4: byte write enables, 0 means read.
REQ-011 SHALL have data_addr input DW and data_wdata input DW: load/store address, store data.
REQ-012 SHALL have data_addr_ok output 1 and data_data_ok output 1: load/store accepted, load/store complete.
REQ-013 SHALL have data_rdata output DW: load data.
REQ-014 SHALL have mem_req output 1, mem_wen output 4, mem_addr output DW, mem_wdata output DW: shared SRAM-like port request.
REQ-015 SHALL have mem_addr_ok input 1, mem_data_ok input 1, mem_rdata input DW: shared port responses.
REQ-016 SHALL have stall_req output 1: pipeline stall request to the stall controller.

Function
REQ-017 SHALL implement FSM IDLE, ADDR, WAIT, with at most one outstanding transaction.
REQ-018 In IDLE, SHALL grant combinationally: single requester wins; both requesting -> requester not served last wins (last_owner register, reset value INST so DATA wins first tie).
REQ-019 In IDLE, granted requester's addr_ok SHALL be 1 that cycle; non-granted addr_ok SHALL be 0; on the edge, addr/wen/wdata/owner are captured and FSM -> ADDR.
REQ-020 Captured wen SHALL be 4'b0000 for INST grants.
REQ-021 In ADDR, mem_req SHALL be 1 with captured fields; on mem_addr_ok -> WAIT; if mem_addr_ok and mem_data_ok are both 1, the transaction completes and FSM -> IDLE.
REQ-022 In IDLE/WAIT, mem_req SHALL be 0 and mem_* fields SHALL hold the captured values.
REQ-023 In WAIT, on mem_data_ok the owner's data_ok SHALL pulse 1 that same cycle; last_owner is updated; FSM -> IDLE.
REQ-024 Owner rdata SHALL equal mem_rdata during its data_ok cycle for reads; it SHALL be 0 otherwise, including all write completions.
REQ-025 mem_data_ok in IDLE SHALL be ignored.
REQ-026 Minimum latency SHALL be: addr_ok at cycle 0, mem_req at cycle 1, data_ok at cycle 1 at the earliest.
REQ-027 stall_req SHALL be 1 when (IDLE and (inst_req|data_req)) or (state≠IDLE and not completing this cycle), else 0.
REQ-028 Requesters SHALL be allowed to drop req after addr_ok; req changes after addr_ok SHALL NOT affect the outstanding transaction.

Reset
REQ-029 On rst, SHALL set FSM to IDLE, last_owner to INST, and captured regs to 0; all addr_ok/data_ok/mem_req/stall_req outputs SHALL be 0 during rst.
REQ-030 rst mid-transaction SHALL discard the transaction with no data_ok; a late mem_data_ok afterwards SHALL be ignored.

Structure
REQ-031 State encodings and the owner encoding SHALL be defined in the shared defines header.
REQ-032 SHALL have one sub-module, rr_arb2: a 2-requester round-robin pick from last_owner.

Verification
REQ-033 Bench SHALL cover: inst_req alone, addr 0xBFC00000, mem_addr_ok at cycle 1, mem_data_ok+rdata 0x3C010001 at cycle 3 -> inst_addr_ok cycle 0, inst_data_ok and inst_rdata=0x3C010001 at cycle 3, stall_req 1 during cycles 0-2.
REQ-034 Bench SHALL cover: both requesting after reset -> data granted first; on next IDLE with both requesting, inst granted.
REQ-035 Bench SHALL cover: store wen=4'b0011, addr 0x80000010, wdata 0xDEADBEEF -> mem_wen=0011 and mem_wdata=0xDEADBEEF while mem_req=1; data_rdata=0 on data_data_ok.
REQ-036 Bench SHALL cover: mem_addr_ok and mem_data_ok in the same cycle -> completion that cycle, with mem_req=0 next cycle.
REQ-037 Bench SHALL cover: rst asserted in WAIT, then mem_data_ok 2 cycles later -> no data_ok and FSM in IDLE.
REQ-038 Bench SHALL cover: mem_addr_ok held 0 for 5 cycles -> mem_req and stall_req held 1 with fields stable.
